// File: rtl/serial_full_adder.sv
// Bit-serial adder: adds a + b + cin LSB-first through one full-adder cell and a carry flop.
// Optional signed-overflow output is enabled with the SERIAL_ADDER_OVF_EN macro.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic bit_s, carry_out, last_bit;

  assign bit_s     = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_out = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit  = (cnt == LAST);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
  // busy/done are registered from next state so every output comes straight off a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are small flop banks, not RAM, so they reset cleanly here.
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
          carry  <= carry_out;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= {bit_s, sum_sr[WIDTH-1:1]};
            cout <= carry_out;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB is the current carry; carry out of it is carry_out.
            ovf  <= carry ^ carry_out;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
